// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus of imem_fetch_ctrl: instruction-memory port, redirect input,
// decode-facing valid/ready output and status flags.
interface imem_fetch_ctrl_if #(
  parameter int N   = 32,
  parameter int AW  = 6,
  parameter int PCW = 64
);
  logic           fetch_en;
  logic [AW-1:0]  imem_addr;
  logic [N-1:0]   imem_q;
  logic           br_valid;
  logic [PCW-1:0] br_target;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_instr;
  logic [PCW-1:0] out_pc;
  logic           halted;
  logic           fault;

  modport master (
    input  fetch_en, imem_q, br_valid, br_target, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, halted, fault
  );

  modport slave (
    output fetch_en, imem_q, br_valid, br_target, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, halted, fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: byte PC, 2-entry fetch queue, redirect and fault handling.
// Optional halt-idiom detection is enabled by defining IMEM_HALT_DETECT_EN.
module imem_fetch_ctrl #(
  parameter int N   = 32,
  parameter int AW  = 6,
  parameter int PCW = 64
) (
  input logic              clk,
  input logic              reset,
  imem_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_e;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [N-1:0]   instr;
  } entry_t;

`ifdef IMEM_HALT_DETECT_EN
  localparam logic [N-1:0] HALT_WORD = N'(32'hb400001f);
  logic halted_q, halted_d;
`endif

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [1:0]      cnt_q, cnt_d;
  entry_t [1:0]    q_q, q_d;
  entry_t          fetched;
  logic            out_valid, pop, push, redirect, pc_oob;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign redirect  = bus.br_valid && (state_q != FAULT);
  assign pc_oob    = |pc_q[PCW-1:AW+2];
  assign fetched   = '{pc: pc_q, instr: bus.imem_q};

  // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    push    = 1'b0;
`ifdef IMEM_HALT_DETECT_EN
    halted_d = halted_q;
`endif

    if (redirect) begin
      // Redirect wins over push, pop and fetch_en; any head popped this cycle is discarded.
      cnt_d = 2'd0;
`ifdef IMEM_HALT_DETECT_EN
      halted_d = 1'b0;
`endif
      if (|bus.br_target[1:0]) begin
        state_d = FAULT;
      end else begin
        pc_d    = bus.br_target;
        state_d = bus.fetch_en ? RUN : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: if (bus.fetch_en) state_d = RUN;
        RUN: begin
          if (!bus.fetch_en)  state_d = IDLE;
          else if (pc_oob)    state_d = FAULT;
          else                push    = (cnt_q != 2'd2) || pop;
        end
        default: ;
      endcase

      if (push) begin
        pc_d = pc_q + PCW'(4);
`ifdef IMEM_HALT_DETECT_EN
        if (bus.imem_q == HALT_WORD) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
`endif
      end

      // Head lives in slot 0; a pop shifts slot 1 down.
      if (push && pop) begin
        if (cnt_q == 2'd2) begin
          q_d[0] = q_q[1];
          q_d[1] = fetched;
        end else begin
          q_d[0] = fetched;
        end
      end else if (push) begin
        q_d[cnt_q[0]] = fetched;
        cnt_d         = cnt_q + 2'd1;
      end else if (pop) begin
        q_d[0] = q_q[1];
        cnt_d  = cnt_q - 2'd1;
      end

      if (state_d == FAULT) cnt_d = 2'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      // NOTE: queue storage is reset because out_instr/out_pc must read 0 out of reset.
      q_q     <= '0;
`ifdef IMEM_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
`ifdef IMEM_HALT_DETECT_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign bus.imem_addr = pc_q[AW+1:2];
  assign bus.out_valid = out_valid;
  assign bus.out_instr = q_q[0].instr;
  assign bus.out_pc    = q_q[0].pc;
  assign bus.fault     = (state_q == FAULT);
`ifdef IMEM_HALT_DETECT_EN
  assign bus.halted    = halted_q;
`else
  assign bus.halted    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios plus randomized
// ready/enable/redirect traffic checked against an expected instruction stream.
module tb_imem_fetch_ctrl;
  localparam int N   = 32;
  localparam int AW  = 6;
  localparam int PCW = 64;
  localparam logic [31:0] HALT_WORD = 32'hb400001f;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom [64];
  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_deliv = 0;
  logic [63:0] last_pc = '0;

  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.N(N), .AW(AW), .PCW(PCW)) bus ();

  imem_fetch_ctrl #(.N(N), .AW(AW), .PCW(PCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_q = rom[bus.imem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Expected delivery order after a restart at 'start': consecutive words up to
  // the end of memory, or up to and including the halt idiom when detection is on.
  function automatic void load_stream(input logic [63:0] start);
    exp_t e;
    exp_q.delete();
    for (int i = int'(start >> 2); i < 64; i++) begin
      e.pc    = 64'(i) * 64'd4;
      e.instr = rom[i];
      exp_q.push_back(e);
`ifdef IMEM_HALT_DETECT_EN
      if (rom[i] == HALT_WORD) break;
`endif
    end
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    bus.br_valid = 1'b0;
    load_stream(64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_deliv = 0;
  endtask

  task automatic redirect(input logic [63:0] target, input bit expect_stream);
    bus.br_valid  = 1'b1;
    bus.br_target = target;
    if (expect_stream) load_stream(target);
    else exp_q.delete();
    @(posedge clk);
    #1 bus.br_valid = 1'b0;
  endtask

  // Monitor: every accepted head must be the next word of the expected stream.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !bus.br_valid && bus.out_valid && bus.out_ready) begin
      n_deliv++;
      last_pc = bus.out_pc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_delivery: got pc 0x%0h, required no delivery", bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        check("deliv_pc", bus.out_pc, e.pc);
        check("deliv_instr", 64'(bus.out_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i);
    rom[10] = HALT_WORD;
    bus.fetch_en  = 1'b0;
    bus.out_ready = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = '0;

    // Reset state
    do_reset();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_instr", 64'(bus.out_instr), 64'd0);
    check("rst_pc", bus.out_pc, 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_fault", 64'(bus.fault), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'd0);

    // First-fetch latency and streaming
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1 check("cyc1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("cyc2_valid", 64'(bus.out_valid), 64'd1);
    check("cyc2_pc", bus.out_pc, 64'd0);
    check("cyc2_instr", 64'(bus.out_instr), 64'h1000_0000);
    @(posedge clk); #1;
    check("cyc3_pc", bus.out_pc, 64'd4);
    check("cyc3_instr", 64'(bus.out_instr), 64'h1000_0001);

    // Backpressure: queue saturates, head and PC hold
    bus.out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 10 && !bus.out_valid; k++) begin @(posedge clk); #1; end
    check("stall_first_valid", 64'(bus.out_valid), 64'd1);
    repeat (5) begin @(posedge clk); #1; end
    check("stall_instr", 64'(bus.out_instr), 64'h1000_0000);
    check("stall_pc", bus.out_pc, 64'd0);
    check("stall_addr", 64'(bus.imem_addr), 64'd2);
    n_deliv = 0;
    bus.out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("release_count", 64'(n_deliv), 64'd3);
    check("release_last_pc", last_pc, 64'h8);

    // Redirect with a full queue
    bus.out_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    redirect(64'h20, 1'b1);
    check("redir_gap_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("redir_pc", bus.out_pc, 64'h20);
    check("redir_instr", 64'(bus.out_instr), 64'h1000_0008);
    repeat (4) begin @(posedge clk); #1; end

    // Misaligned redirect: sticky fault, later redirects ignored
    redirect(64'h22, 1'b0);
    check("mis_fault", 64'(bus.fault), 64'd1);
    check("mis_valid", 64'(bus.out_valid), 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    redirect(64'h0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("mis_fault_sticky", 64'(bus.fault), 64'd1);
    check("mis_valid_sticky", 64'(bus.out_valid), 64'd0);
    do_reset();
    check("mis_fault_cleared", 64'(bus.fault), 64'd0);

    // Free run off the end of memory
`ifdef IMEM_HALT_DETECT_EN
    rom[10] = 32'h0;
`endif
    do_reset();
    for (int k = 0; k < 200 && !bus.fault; k++) begin @(posedge clk); #1; end
    check("oob_fault", 64'(bus.fault), 64'd1);
    check("oob_all_delivered", 64'(exp_q.size()), 64'd0);
    check("oob_last_pc", last_pc, 64'hFC);
    check("oob_valid", 64'(bus.out_valid), 64'd0);
    rom[10] = HALT_WORD;

`ifdef IMEM_HALT_DETECT_EN
    // Halt idiom: delivered, then fetching stops until a redirect
    do_reset();
    for (int k = 0; k < 100 && !bus.halted; k++) begin @(posedge clk); #1; end
    check("halt_seen", 64'(bus.halted), 64'd1);
    repeat (5) begin @(posedge clk); #1; end
    check("halt_all_delivered", 64'(exp_q.size()), 64'd0);
    check("halt_last_pc", last_pc, 64'h28);
    check("halt_valid", 64'(bus.out_valid), 64'd0);
    check("halt_held", 64'(bus.halted), 64'd1);
    redirect(64'h0, 1'b1);
    check("halt_cleared", 64'(bus.halted), 64'd0);
    repeat (8) begin @(posedge clk); #1; end
    check("halt_resume_pc", last_pc, 64'h18);
`endif

    // Randomized ready / enable / redirect / reset traffic
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.fetch_en  = ($urandom_range(0, 7) != 0);
      if (bus.fault) do_reset();
      else if (r < 4) redirect(64'($urandom_range(0, 63)) * 64'd4, 1'b1);
      else if (r < 5) do_reset();
      else begin @(posedge clk); #1; end
    end

    bus.out_ready = 1'b1;
    repeat (20) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
